// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: write-side state encoding and Ethernet frame-size limits shared by the receive FIFO.
package eth_rx_pkg;
   typedef enum logic [1:0] {S_SYNC, S_IDLE, S_WRITE, S_DROP} wr_state_t;
   localparam int C_ETH_MIN_FRAME = 60;
   localparam int C_ETH_MAX_FRAME = 1514;
endpackage

// File: rtl/eth_rx_frame_fifo_sdp_ram.sv
// sdp_ram: simple dual-port RAM with a registered read port, written to infer block RAM.
module sdp_ram #(
   parameter int W = 9,
   parameter int D = 2048,
   localparam int AW = $clog2(D)
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);
   logic [W-1:0] r_mem [D];
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_raddr];
   end
endmodule

// File: rtl/eth_rx_frame_fifo.sv
// eth_rx_frame_fifo: store-and-forward receive buffer; frames are written speculatively and
// only committed, error-free frames are released to the flow-controlled AXIS output.
module eth_rx_frame_fifo
   import eth_rx_pkg::*;
#(
   parameter int C_DEPTH = 2048,
   parameter int C_FRAME_MAX = 32,
   localparam int AW = $clog2(C_DEPTH),
   localparam int AW1 = AW + 1,
   localparam int FW = $clog2(C_FRAME_MAX) + 1
) (
   input  logic          rx_mac_aclk,
   input  logic          rx_mac_resetn,
   input  logic [7:0]    rx_axis_mac_tdata,
   input  logic          rx_axis_mac_tvalid,
   input  logic          rx_axis_mac_tlast,
   input  logic          rx_axis_mac_tuser,
   output logic [7:0]    rx_axis_fifo_tdata,
   output logic          rx_axis_fifo_tvalid,
   input  logic          rx_axis_fifo_tready,
   output logic          rx_axis_fifo_tlast,
   output logic [FW-1:0] rx_fifo_frame_cnt,
   output logic [15:0]   rx_fifo_good_cnt,
   output logic [15:0]   rx_fifo_drop_cnt,
   output logic          rx_fifo_overflow
);
   localparam logic [AW:0]   LP_FULL = AW1'(C_DEPTH);
   localparam logic [FW-1:0] LP_FMAX = FW'(C_FRAME_MAX);
   wr_state_t     r_state;
   logic [AW:0]   r_wr_ptr, r_wr_commit, r_rd_ptr;
   logic [FW-1:0] r_frame_cnt;
   logic [15:0]   r_good_cnt, r_drop_cnt;
   logic          r_ovf, r_pend, r_vld, r_sk_vld;
   logic [8:0]    r_out, r_sk;
   logic [8:0]    w_ram_q;
   logic [1:0]    w_occ;
   logic          w_full, w_limit, w_take, w_bad, w_we, w_commit, w_drop, w_pop, w_issue;
   assign w_full   = (r_wr_ptr - r_rd_ptr) == LP_FULL;
   assign w_limit  = r_state == S_IDLE && r_frame_cnt == LP_FMAX;
   assign w_take   = rx_axis_mac_tvalid && (r_state == S_WRITE || (r_state == S_IDLE && !w_limit));
   assign w_bad    = w_full || (rx_axis_mac_tlast && rx_axis_mac_tuser);
   assign w_we     = w_take && !w_bad;
   assign w_commit = w_we && rx_axis_mac_tlast;
   assign w_drop   = rx_axis_mac_tvalid && rx_axis_mac_tlast &&
                     ((w_take && w_bad) || r_state == S_DROP || w_limit);
   always_ff @(posedge rx_mac_aclk or negedge rx_mac_resetn) begin
      if (!rx_mac_resetn) begin
         r_state     <= S_SYNC;
         r_wr_ptr    <= '0;
         r_wr_commit <= '0;
         r_good_cnt  <= '0;
         r_drop_cnt  <= '0;
         r_ovf       <= 1'b0;
      end else begin
         r_ovf      <= w_take && w_full;
         r_good_cnt <= r_good_cnt + 16'(w_commit);
         r_drop_cnt <= r_drop_cnt + 16'(w_drop);
         if (rx_axis_mac_tvalid) begin
            case (r_state)
               S_SYNC: r_state <= rx_axis_mac_tlast ? S_IDLE : S_SYNC;
               S_DROP: begin
                  r_wr_ptr <= r_wr_commit;
                  r_state  <= rx_axis_mac_tlast ? S_IDLE : S_DROP;
               end
               S_IDLE, S_WRITE: begin
                  r_wr_ptr <= w_we ? r_wr_ptr + 1'b1 : r_wr_commit;
                  if (w_commit) r_wr_commit <= r_wr_ptr + 1'b1;
                  r_state <= rx_axis_mac_tlast ? S_IDLE : (w_we ? S_WRITE : S_DROP);
               end
            endcase
         end
      end
   end
   sdp_ram #(.W(9), .D(C_DEPTH)) u_ram (
      .i_clk   (rx_mac_aclk),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr[AW-1:0]),
      .i_wdata ({rx_axis_mac_tlast, rx_axis_mac_tdata}),
      .i_re    (w_issue),
      .i_raddr (r_rd_ptr[AW-1:0]),
      .o_rdata (w_ram_q)
   );
   // Output register plus skid entry; a read is only issued if its data will have a home.
   assign w_pop   = r_vld && rx_axis_fifo_tready;
   assign w_occ   = 2'(r_vld) + 2'(r_sk_vld) + 2'(r_pend) - 2'(w_pop);
   assign w_issue = r_rd_ptr != r_wr_commit && w_occ <= 2'd1;
   always_ff @(posedge rx_mac_aclk or negedge rx_mac_resetn) begin
      if (!rx_mac_resetn) begin
         r_rd_ptr    <= '0;
         r_pend      <= 1'b0;
         r_vld       <= 1'b0;
         r_sk_vld    <= 1'b0;
         r_out       <= '0;
         r_sk        <= '0;
         r_frame_cnt <= '0;
      end else begin
         r_rd_ptr    <= r_rd_ptr + AW1'(w_issue);
         r_pend      <= w_issue;
         r_frame_cnt <= r_frame_cnt + FW'(w_commit) - FW'(w_pop && r_out[8]);
         if (!r_vld || w_pop) begin
            r_vld    <= r_sk_vld || r_pend;
            r_out    <= r_sk_vld ? r_sk : (r_pend ? w_ram_q : r_out);
            r_sk_vld <= r_sk_vld && r_pend;
            if (r_pend) r_sk <= w_ram_q;
         end else if (r_pend) begin
            r_sk_vld <= 1'b1;
            r_sk     <= w_ram_q;
         end
      end
   end
   assign rx_axis_fifo_tdata  = r_out[7:0];
   assign rx_axis_fifo_tlast  = r_out[8];
   assign rx_axis_fifo_tvalid = r_vld;
   assign rx_fifo_frame_cnt   = r_frame_cnt;
   assign rx_fifo_good_cnt    = r_good_cnt;
   assign rx_fifo_drop_cnt    = r_drop_cnt;
   assign rx_fifo_overflow    = r_ovf;
endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// tb_eth_rx_frame_fifo: three parameterisations share one MAC stream; a byte-queue model of the
// committed frames is compared against whichever instance the current scenario selects.
module tb_eth_rx_frame_fifo;
   import eth_rx_pkg::*;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic       rstn, v, l, u, rdy;
   logic [7:0] d;
   logic [7:0] o_d [3];
   logic       o_v [3], o_l [3], o_ovf [3];
   logic [15:0] o_g [3], o_dr [3];
   logic [5:0] fc0, fc1;
   logic [2:0] fc2;
   int         sel = 0;
   logic [7:0] m_d, m_fc;
   logic       m_v, m_l, m_ovf;
   logic [15:0] m_g, m_dr;
   eth_rx_frame_fifo #(.C_DEPTH(2048), .C_FRAME_MAX(32)) u_main (
      .rx_mac_aclk(clk), .rx_mac_resetn(rstn),
      .rx_axis_mac_tdata(d), .rx_axis_mac_tvalid(v), .rx_axis_mac_tlast(l), .rx_axis_mac_tuser(u),
      .rx_axis_fifo_tdata(o_d[0]), .rx_axis_fifo_tvalid(o_v[0]), .rx_axis_fifo_tready(rdy),
      .rx_axis_fifo_tlast(o_l[0]), .rx_fifo_frame_cnt(fc0), .rx_fifo_good_cnt(o_g[0]),
      .rx_fifo_drop_cnt(o_dr[0]), .rx_fifo_overflow(o_ovf[0]));
   eth_rx_frame_fifo #(.C_DEPTH(64), .C_FRAME_MAX(32)) u_ovf (
      .rx_mac_aclk(clk), .rx_mac_resetn(rstn),
      .rx_axis_mac_tdata(d), .rx_axis_mac_tvalid(v), .rx_axis_mac_tlast(l), .rx_axis_mac_tuser(u),
      .rx_axis_fifo_tdata(o_d[1]), .rx_axis_fifo_tvalid(o_v[1]), .rx_axis_fifo_tready(rdy),
      .rx_axis_fifo_tlast(o_l[1]), .rx_fifo_frame_cnt(fc1), .rx_fifo_good_cnt(o_g[1]),
      .rx_fifo_drop_cnt(o_dr[1]), .rx_fifo_overflow(o_ovf[1]));
   eth_rx_frame_fifo #(.C_DEPTH(512), .C_FRAME_MAX(4)) u_lim (
      .rx_mac_aclk(clk), .rx_mac_resetn(rstn),
      .rx_axis_mac_tdata(d), .rx_axis_mac_tvalid(v), .rx_axis_mac_tlast(l), .rx_axis_mac_tuser(u),
      .rx_axis_fifo_tdata(o_d[2]), .rx_axis_fifo_tvalid(o_v[2]), .rx_axis_fifo_tready(rdy),
      .rx_axis_fifo_tlast(o_l[2]), .rx_fifo_frame_cnt(fc2), .rx_fifo_good_cnt(o_g[2]),
      .rx_fifo_drop_cnt(o_dr[2]), .rx_fifo_overflow(o_ovf[2]));
   always_comb begin
      m_d   = o_d[sel];
      m_v   = o_v[sel];
      m_l   = o_l[sel];
      m_ovf = o_ovf[sel];
      m_g   = o_g[sel];
      m_dr  = o_dr[sel];
      m_fc  = sel == 0 ? 8'(fc0) : (sel == 1 ? 8'(fc1) : 8'(fc2));
   end
   int n_vec = 0, n_err = 0;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask
   logic [8:0] exp_q [$];
   logic       prev_stall = 1'b0;
   logic [8:0] prev_ld = '0;
   int         ovf_n = 0;
   bit         rand_rdy = 1'b0;
   // Outputs are sampled on the falling edge; a beat seen here is accepted on the next rising edge.
   always @(negedge clk) begin
      if (rstn && prev_stall) chk("hold", {m_v, m_l, m_d}, {1'b1, prev_ld});
      if (rstn && m_v && rdy) begin
         if (exp_q.size() == 0) chk("extra_beat", 32'(exp_q.size()), 1);
         else chk("beat", {m_l, m_d}, exp_q.pop_front());
      end
      if (rstn && m_ovf) ovf_n++;
      prev_stall = rstn && m_v && !rdy;
      prev_ld = {m_l, m_d};
   end
   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) rdy = 1'($urandom_range(0, 1));
   endtask
   task automatic send_frame(input int len, input bit err, input bit keep, input int base,
                             input int gap_pct, input int rst_at);
      logic [8:0] f [$];
      for (int i = 0; i < len; i++) begin
         while (int'($urandom_range(0, 99)) < gap_pct) begin
            v = 1'b0;
            l = 1'($urandom);
            d = 8'($urandom);
            tick();
         end
         if (i == rst_at) rstn = 1'b0;
         if (i == rst_at + 3) rstn = 1'b1;
         d = base < 0 ? 8'($urandom) : 8'(base + i);
         l = i == len - 1;
         u = l ? err : 1'($urandom);
         v = 1'b1;
         f.push_back({l, d});
         tick();
      end
      v = 1'b0;
      l = 1'b0;
      u = 1'b0;
      if (keep) foreach (f[k]) exp_q.push_back(f[k]);
   endtask
   task automatic sync_beat();
      send_frame(1, 1'b0, 1'b0, 0, 0, -1);
   endtask
   task automatic do_reset(input int s);
      rstn = 1'b0;
      v = 1'b0;
      l = 1'b0;
      u = 1'b0;
      d = '0;
      rand_rdy = 1'b0;
      sel = s;
      exp_q.delete();
      ovf_n = 0;
      repeat (3) tick();
      rstn = 1'b1;
      tick();
   endtask
   task automatic drain(input string tag, input int budget);
      int t = 0;
      while ((exp_q.size() != 0 || m_v) && t < budget) begin
         tick();
         t++;
      end
      chk({tag, "_left"}, 32'(exp_q.size()), 0);
      chk({tag, "_tvalid"}, 32'(m_v), 0);
   endtask
   int len, t, ng, nd;
   bit err;
   initial begin
      rstn = 1'b0;
      rdy = 1'b0;
      do_reset(0);
      for (int s = 0; s < 3; s++) begin
         chk("rst_tvalid", 32'(o_v[s]), 0);
         chk("rst_tlast", 32'(o_l[s]), 0);
         chk("rst_tdata", 32'(o_d[s]), 0);
         chk("rst_ovf", 32'(o_ovf[s]), 0);
         chk("rst_good", 32'(o_g[s]), 0);
         chk("rst_drop", 32'(o_dr[s]), 0);
      end
      chk("rst_fc0", 32'(fc0), 0);
      chk("rst_fc1", 32'(fc1), 0);
      chk("rst_fc2", 32'(fc2), 0);
      // single 60-byte frame, latency and back-to-back output
      rdy = 1'b1;
      sync_beat();
      send_frame(C_ETH_MIN_FRAME, 1'b0, 1'b1, 0, 0, -1);
      chk("t1_good", 32'(m_g), 1);
      chk("t1_fc", 32'(m_fc), 1);
      chk("t1_lat0", 32'(m_v), 0);
      tick();
      chk("t1_lat1", 32'(m_v), 0);
      tick();
      chk("t1_lat2", 32'(m_v), 1);
      chk("t1_first", 32'(m_d), 0);
      repeat (59) tick();
      chk("t1_nobubble", 32'(exp_q.size()), 1);
      drain("t1", 200);
      chk("t1_fc_end", 32'(m_fc), 0);
      chk("t1_good_end", 32'(m_g), 1);
      // bad frame between two good ones
      do_reset(0);
      rdy = 1'b1;
      sync_beat();
      send_frame(64, 1'b0, 1'b1, -1, 0, -1);
      send_frame(100, 1'b1, 1'b0, -1, 0, -1);
      send_frame(64, 1'b0, 1'b1, -1, 0, -1);
      drain("t2", 500);
      chk("t2_good", 32'(m_g), 2);
      chk("t2_drop", 32'(m_dr), 1);
      chk("t2_fc", 32'(m_fc), 0);
      // overflow on the 64-byte instance
      do_reset(1);
      rdy = 1'b0;
      sync_beat();
      send_frame(40, 1'b0, 1'b1, -1, 0, -1);
      send_frame(40, 1'b0, 1'b0, -1, 0, -1);
      repeat (4) tick();
      chk("t3_ovf", 32'(ovf_n), 1);
      chk("t3_fc", 32'(m_fc), 1);
      chk("t3_drop", 32'(m_dr), 1);
      rdy = 1'b1;
      drain("t3", 200);
      chk("t3_good", 32'(m_g), 1);
      chk("t3_fc_end", 32'(m_fc), 0);
      chk("t3_ovf_end", 32'(ovf_n), 1);
      // random frames, random errors and input gaps, 50% tready
      do_reset(0);
      rdy = 1'b1;
      sync_beat();
      rand_rdy = 1'b1;
      ng = 0;
      nd = 0;
      for (int k = 0; k < 20; k++) begin
         len = int'($urandom_range(C_ETH_MIN_FRAME, C_ETH_MAX_FRAME));
         err = $urandom_range(0, 4) == 0;
         t = 0;
         while (exp_q.size() + len > 2048 && t < 20000) begin
            tick();
            t++;
         end
         chk("t4_room", 32'(exp_q.size() + len <= 2048), 1);
         send_frame(len, err, !err, -1, 10, -1);
         ng += int'(!err);
         nd += int'(err);
      end
      drain("t4", 20000);
      rand_rdy = 1'b0;
      chk("t4_good", 32'(m_g), 32'(ng));
      chk("t4_drop", 32'(m_dr), 32'(nd));
      chk("t4_fc", 32'(m_fc), 0);
      // reset for 3 cycles at byte 30, then a clean frame
      do_reset(0);
      rdy = 1'b1;
      sync_beat();
      send_frame(60, 1'b0, 1'b0, 0, 0, 30);
      chk("t5_good0", 32'(m_g), 0);
      chk("t5_drop0", 32'(m_dr), 0);
      send_frame(60, 1'b0, 1'b1, 100, 0, -1);
      drain("t5", 300);
      chk("t5_good", 32'(m_g), 1);
      chk("t5_drop", 32'(m_dr), 0);
      chk("t5_fc", 32'(m_fc), 0);
      // frame limit of 4 with output stalled
      do_reset(2);
      rdy = 1'b0;
      sync_beat();
      for (int k = 0; k < 6; k++) send_frame(60, 1'b0, k < 4, -1, 0, -1);
      tick();
      chk("t6_fc", 32'(m_fc), 4);
      chk("t6_drop", 32'(m_dr), 2);
      chk("t6_good", 32'(m_g), 4);
      chk("t6_ovf", 32'(ovf_n), 0);
      rdy = 1'b1;
      drain("t6", 600);
      chk("t6_fc_end", 32'(m_fc), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/eth_rx_frame_fifo.md
# eth_rx_frame_fifo

Store-and-forward receive frame buffer placed directly downstream of the tri-mode MAC receive stage, on the same `rx_mac_aclk` domain. It accepts the MAC's byte stream, which has no backpressure, and writes every frame speculatively. A frame is committed when its `tlast` beat arrives with `tuser` = 0. A frame is rewound (discarded) when `tuser` = 1 at `tlast`, or when the buffer overflows. Only complete, error-free frames are presented to the user AXIS interface, which has full `tready` flow control.

## Interface
Parameters:
- `C_DEPTH`, 2048: data buffer size in bytes; must be a power of 2 and ≥ 64.
- `C_FRAME_MAX`, 32: maximum committed-but-unread frames; must be a power of 2.

Ports:
- `rx_mac_aclk`  in  1  clock.
- `rx_mac_resetn`  in  1  asynchronous active-low reset.
- `rx_axis_mac_tdata`  in  8  MAC data byte.
- `rx_axis_mac_tvalid`  in  1  byte valid; there is no ready signal and every valid beat is consumed.
- `rx_axis_mac_tlast`  in  1  last byte of frame; sampled only when `tvalid` = 1.
- `rx_axis_mac_tuser`  in  1  frame error; sampled only on the `tlast` beat.
- `rx_axis_fifo_tdata`  out  8  user data.
- `rx_axis_fifo_tvalid`  out  1  user valid.
- `rx_axis_fifo_tready`  in  1  user ready.
- `rx_axis_fifo_tlast`  out  1  last byte of committed frame.
- `rx_fifo_frame_cnt`  out  clog2(`C_FRAME_MAX`)+1  committed frames not yet fully read.
- `rx_fifo_good_cnt`  out  16  committed frames; wraps at 16 bits.
- `rx_fifo_drop_cnt`  out  16  discarded frames; wraps at 16 bits.
- `rx_fifo_overflow`  out  1  one-cycle pulse when a frame is dropped for lack of space.

## Operation
- Storage is a simple dual-port RAM of `C_DEPTH` × 9 bits: `{tlast, tdata}`.
- Pointers are `wr_ptr`, `wr_commit` and `rd_ptr`. Each is clog2(`C_DEPTH`)+1 bits wide; the extra MSB distinguishes full from empty. All arithmetic is modulo 2^(AW+1).
- Used space = `wr_ptr` − `rd_ptr`. The buffer is full when used space = `C_DEPTH`.
- Write FSM:
  - `S_SYNC`: the reset state. Discards beats until a `tlast` beat has been seen, then goes to `S_IDLE`. This prevents committing the tail of a frame that was in flight during reset.
  - `S_IDLE` → `S_WRITE` on a valid non-`tlast` beat. A single-beat frame (valid with `tlast`) is handled in place with the same rules as a `tlast` beat in `S_WRITE`.
  - `S_WRITE`: each beat is written at `wr_ptr`, then `wr_ptr` increments.
    - A `tlast` beat with `tuser` = 0: commit. `wr_commit` takes the post-increment `wr_ptr` on the same edge, and `good_cnt` increments. Go to `S_IDLE`.
    - A `tlast` beat with `tuser` = 1: the beat is not written, `wr_ptr` takes `wr_commit`, and `drop_cnt` increments. Go to `S_IDLE`.
    - A beat that arrives while full: pulse `rx_fifo_overflow`. If the beat is not `tlast`, go to `S_DROP`. If it is `tlast`, apply the rewind immediately.
  - `S_DROP`: nothing is written; `wr_ptr` takes `wr_commit`. On a `tlast` beat, `drop_cnt` increments and the FSM goes to `S_IDLE`, regardless of `tuser`.
  - Frame limit: a frame whose first beat arrives while `frame_cnt` = `C_FRAME_MAX` goes straight to `S_DROP`. No overflow pulse is raised; the frame still counts toward `drop_cnt`.
- Read side:
  - Reads fetch from `rd_ptr` while `rd_ptr` ≠ `wr_commit`.
  - A 2-entry prefetch buffer sustains one byte per cycle while `tready` = 1.
  - `tvalid`, once asserted, is held with stable data and `tlast` until `tready` = 1 (AXIS rules).
- `frame_cnt`: +1 on commit, −1 when the output accepts a `tlast` beat; if both happen on the same cycle it is unchanged.
- Space is released byte by byte as bytes are read. `wr_commit` is never passed by `rd_ptr`.

## Timing
- Reset values:
  - All pointers and counters are 0.
  - FSM is in `S_SYNC`.
  - `rx_axis_fifo_tvalid`, `tlast` and `rx_fifo_overflow` are 0.
  - `tdata` is 0.
- Latency: with the output empty, `rx_axis_fifo_tvalid` rises 2 cycles after the edge that writes the committing `tlast` beat. The first byte is on `tdata` in that same cycle.
- Throughput: 1 byte per cycle on both sides. With `tready` held at 1, there are no bubbles within a frame or between committed frames.
- A rewind or commit on the same edge as a read needs no arbitration, because the pointers are owned by separate sides.
- `frame_cnt`, `good_cnt` and `drop_cnt` are registered and update on the edge after the triggering beat.
- Reset asserted mid-frame clears the buffer immediately, including any frame being output.

## Structure
- A shared package `eth_rx_pkg` holds:
  - the FSM state encoding (`S_SYNC`, `S_IDLE`, `S_WRITE`, `S_DROP`);
  - the constants `C_ETH_MIN_FRAME` = 60 and `C_ETH_MAX_FRAME` = 1514.
- One sub-module, `sdp_ram`: a parameterised simple dual-port RAM (width, depth) with a registered read port, inferable as block RAM.

## Test plan
- Single frame: 60 good bytes 0x00..0x3B, `tuser` = 0, `tready` = 1 → identical 60 bytes out, `tlast` on 0x3B, `good_cnt` = 1, `frame_cnt` returns to 0.
- Bad frame between good frames: good A (64 B), bad B (100 B, `tuser` = 1), good C (64 B) → output is A then C only; `drop_cnt` = 1, `good_cnt` = 2.
- Overflow: `C_DEPTH` = 64, `tready` = 0, a 40 B frame followed by a 40 B frame → second frame dropped, `rx_fifo_overflow` pulses once, and only the first frame is output after `tready` = 1.
- Backpressure: `tready` toggled at random with 50% duty over 20 random-length frames (60–1514 B) → byte-exact output, and `tvalid`/`tdata` stay stable while stalled.
- Reset mid-frame: `rx_mac_resetn` low for 3 cycles at byte 30 of 60 → the remaining 30 bytes are discarded (`S_SYNC`), and the next good frame is output intact with `good_cnt` = 1.
- Frame limit: `C_FRAME_MAX` = 4, `tready` = 0, 6 frames of 60 B → `frame_cnt` = 4 and `drop_cnt` = 2.
